spi_master_arbiter: RTL and testbench
=====================================

SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 The parameters SHALL be as follows. NUM_REQ, default 4, is the number of requesters (2..8). DATA_WIDTH, default 8, is the SPI word width. TIMEOUT_CYCLES, default 1023, is the watchdog limit in clk cycles.
REQ-002 clk  in  1  system clock; the design SHALL use one clock, clk, and all state SHALL be rising-edge triggered.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 req_valid  in  NUM_REQ  per-requester transaction request.
REQ-005 req_data  in  NUM_REQ*DATA_WIDTH  packed TX words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 req_ready  out  NUM_REQ  one-hot acceptance pulse.
REQ-007 resp_valid  out  NUM_REQ  one-hot completion pulse.
REQ-008 resp_data  out  DATA_WIDTH  received word, shared by all requesters.
REQ-009 resp_err  out  1  completion ended by timeout.
REQ-010 m_tx_data  out  DATA_WIDTH  word to the SPI master.
REQ-011 m_tx_valid  out  1  start request to the SPI master.
REQ-012 m_tx_ready  in  1  SPI master idle/ready.
REQ-013 m_rx_data  in  DATA_WIDTH  SPI master received word.
REQ-014 m_rx_valid  in  1  SPI master one-cycle receive strobe.
REQ-015 cs_sel  out  NUM_REQ  one-hot slave-select steering.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, encoded in 2 bits, with any illegal encoding returning to IDLE.
REQ-018 IDLE, when any req_valid bit is high: grant = first requester with req_valid high, searching round-robin from (last_grant+1) mod NUM_REQ.
REQ-019 IDLE, same cycle: latch req_data[grant] and the grant index, assert req_ready[grant] combinationally, and move to ISSUE next cycle.
REQ-020 A request SHALL be accepted only in the cycle where req_valid[i] and req_ready[i] are both high; req_valid changes after acceptance SHALL NOT affect the transaction in flight.
REQ-021 ISSUE: hold m_tx_valid=1 with m_tx_data = latched word until a cycle where m_tx_valid and m_tx_ready are both high, then deassert m_tx_valid and move to WAIT.
REQ-022 ISSUE: m_tx_valid SHALL be deasserted in every other state.
REQ-023 WAIT: on m_rx_valid, register m_rx_data into resp_data and move to RESP.
REQ-024 m_rx_valid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-025 RESP: pulse resp_valid[grant] for exactly one cycle, set last_grant = grant, and move to IDLE.
REQ-026 resp_data and resp_err SHALL hold their values until the next RESP.
REQ-027 cs_sel SHALL equal the one-hot grant in ISSUE, WAIT and RESP, and SHALL be 0 in IDLE.
REQ-028 There SHALL be at most one outstanding transaction, and req_ready SHALL be 0 outside IDLE.
REQ-029 Minimum turnaround SHALL be 1 IDLE cycle between consecutive grants.
REQ-030 Under all-requesters-active, grants SHALL rotate 0,1,...,NUM_REQ-1,0,... with no requester starved.
REQ-031 A single active requester SHALL be granted back-to-back.

Reset
REQ-032 Reset SHALL be asynchronous, asserted by rst high, released synchronously to clk.
REQ-033 During reset: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), req_ready=0, resp_valid=0, resp_data=0, resp_err=0, m_tx_valid=0, m_tx_data=0, cs_sel=0, busy=0, timeout counter=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no resp_valid pulse.

Configuration
REQ-035 Macro SPI_ARB_TIMEOUT_EN, when defined: a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-036 With SPI_ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES without m_rx_valid, the block SHALL move to RESP with resp_data=0 and resp_err=1.
REQ-037 With SPI_ARB_TIMEOUT_EN defined, a normal completion SHALL set resp_err=0, and m_rx_valid in the same cycle as the timeout SHALL win.
REQ-038 Without SPI_ARB_TIMEOUT_EN: no counter, WAIT SHALL wait indefinitely, and resp_err SHALL be tied to 0.

Verification
REQ-039 Single request: req_valid[2]=1 with data 0xA5, slave returns 0x3C -> req_ready[2] pulse, m_tx_data=0xA5, cs_sel=4'b0100, resp_valid[2] pulse with resp_data=0x3C.
REQ-040 All four requesting continuously after reset -> grant order 0,1,2,3,0, each receiving exactly one resp_valid per round.
REQ-041 m_tx_ready held low 20 cycles in ISSUE -> m_tx_valid stays 1 with m_tx_data stable, and no WAIT entry until the handshake.
REQ-042 With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no m_rx_valid -> resp_valid pulse 16 cycles after WAIT entry, with resp_err=1 and resp_data=0.
REQ-043 rst asserted in WAIT -> all outputs return to reset values immediately; next request from requester 0 is served normally.
REQ-044 Spurious m_rx_valid in IDLE -> no resp_valid, and resp_data unchanged.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, one transaction at a time.
// Optional WAIT-state watchdog is compiled in when SPI_ARB_TIMEOUT_EN is defined.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic [DATA_WIDTH-1:0]         m_tx_data,
  output logic                          m_tx_valid,
  input  logic                          m_tx_ready,
  input  logic [DATA_WIDTH-1:0]         m_rx_data,
  input  logic                          m_rx_valid,
  output logic [NUM_REQ-1:0]            cs_sel,
  output logic                          busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_master_arbiter: parameter out of range");
  end

  state_t                 state_reg;
  logic [IW-1:0]          last_grant_reg;
  logic [IW-1:0]          grant_reg;
  logic [IW-1:0]          grant_next;
  logic                   grant_found;
  logic [IW-1:0]          cand;
  logic [DATA_WIDTH-1:0]  words [NUM_REQ];
  logic [NUM_REQ-1:0]     resp_valid_reg;
  logic [NUM_REQ-1:0]     cs_sel_reg;
  logic [DATA_WIDTH-1:0]  resp_data_reg;
  logic [DATA_WIDTH-1:0]  m_tx_data_reg;
  logic                   m_tx_valid_reg;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    grant_next  = last_grant_reg;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant_reg) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_next  = cand;
      end
    end
  end

  assign req_ready  = (state_reg == IDLE && grant_found) ? (ONE << grant_next) : '0;
  assign busy       = (state_reg != IDLE);
  assign resp_valid = resp_valid_reg;
  assign cs_sel     = cs_sel_reg;
  assign resp_data  = resp_data_reg;
  assign m_tx_data  = m_tx_data_reg;
  assign m_tx_valid = m_tx_valid_reg;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt_reg;
  logic          resp_err_reg;
  assign resp_err = resp_err_reg;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IW'(NUM_REQ - 1);
      grant_reg      <= '0;
      resp_valid_reg <= '0;
      cs_sel_reg     <= '0;
      resp_data_reg  <= '0;
      m_tx_data_reg  <= '0;
      m_tx_valid_reg <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt_reg     <= '0;
      resp_err_reg   <= 1'b0;
`endif
    end else begin
      resp_valid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            grant_reg      <= grant_next;
            m_tx_data_reg  <= words[grant_next];
            m_tx_valid_reg <= 1'b1;
            cs_sel_reg     <= ONE << grant_next;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_tx_valid_reg && m_tx_ready) begin
            m_tx_valid_reg <= 1'b0;
            state_reg      <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_reg     <= '0;
`endif
          end
        end
        WAIT: begin
          // A receive strobe in the final watchdog cycle still counts as a normal completion.
          if (m_rx_valid) begin
            resp_data_reg  <= m_rx_data;
            resp_valid_reg <= ONE << grant_reg;
            state_reg      <= RESP;
`ifdef SPI_ARB_TIMEOUT_EN
            resp_err_reg   <= 1'b0;
          end else if (to_cnt_reg == TO_LAST) begin
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b1;
            resp_valid_reg <= ONE << grant_reg;
            state_reg      <= RESP;
          end else begin
            to_cnt_reg     <= to_cnt_reg + CW'(1);
`endif
          end
        end
        RESP: begin
          last_grant_reg <= grant_reg;
          cs_sel_reg     <= '0;
          state_reg      <= IDLE;
        end
        default: begin
          m_tx_valid_reg <= 1'b0;
          cs_sel_reg     <= '0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: vector table plus reset, spurious-strobe and watchdog sequences.
module tb_spi_master_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_data;
  logic             resp_err;
  logic [DW-1:0]    m_tx_data;
  logic             m_tx_valid;
  logic             m_tx_ready;
  logic [DW-1:0]    m_rx_data;
  logic             m_rx_valid;
  logic [NR-1:0]    cs_sel;
  logic             busy;

  spi_master_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .m_tx_data(m_tx_data), .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready),
    .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid),
    .cs_sel(cs_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]    valid;
    logic [NR*DW-1:0] data;
    int               grant;
    logic [DW-1:0]    tx;
    logic [DW-1:0]    rx;
    int               rdly;
    int               xdly;
  } vec_t;

  typedef struct {
    int            grant;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  vec_t tbl [11];
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (resp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    if (resp_valid == '0) begin
      check({tag, "_resp_wait"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_resp_valid"}, resp_valid, 32'(4'b1 << e.grant));
    check({tag, "_resp_data"}, resp_data, e.data);
    check({tag, "_resp_err"}, resp_err, e.err);
    check({tag, "_cs_resp"}, cs_sel, 32'(4'b1 << e.grant));
    $display("txn %s: grant %0d resp_data %0h err %0b", tag, e.grant, resp_data, resp_err);
    tick();
    check({tag, "_resp_pulse"}, resp_valid, 32'd0);
    check({tag, "_resp_hold"}, resp_data, e.data);
    check({tag, "_cs_idle"}, cs_sel, 32'd0);
    check({tag, "_busy_idle"}, busy, 32'd0);
  endtask

  // One full transaction: grant in IDLE, optional stalled handshake, delayed receive strobe.
  task automatic run_txn(input string tag, input vec_t v);
    exp_t e;
    int   n;
    req_valid  = v.valid;
    req_data   = v.data;
    m_tx_ready = 1'b0;
    m_rx_valid = 1'b0;
    #1;
    n = 0;
    while (req_ready == '0 && n < 10) begin
      tick();
      n++;
    end
    if (req_ready == '0) begin
      check({tag, "_ready_wait"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_req_ready"}, req_ready, 32'(4'b1 << v.grant));
    e.grant = v.grant;
    e.data  = v.rx;
    e.err   = 1'b0;
    exp_q.push_back(e);
    tick();
    if (v.valid != 4'hF) req_valid = '0;
    req_data = ~v.data;
    #1;
    check({tag, "_issue_valid"}, m_tx_valid, 32'd1);
    check({tag, "_issue_data"}, m_tx_data, v.tx);
    check({tag, "_issue_cs"}, cs_sel, 32'(4'b1 << v.grant));
    check({tag, "_issue_noready"}, req_ready, 32'd0);
    for (int i = 0; i < v.rdly; i++) begin
      tick();
      check({tag, "_stall_valid"}, m_tx_valid, 32'd1);
      check({tag, "_stall_data"}, m_tx_data, v.tx);
    end
    m_tx_ready = 1'b1;
    tick();
    m_tx_ready = 1'b0;
    check({tag, "_wait_txv"}, m_tx_valid, 32'd0);
    check({tag, "_wait_busy"}, busy, 32'd1);
    for (int i = 0; i < v.xdly; i++) begin
      tick();
      check({tag, "_wait_noresp"}, resp_valid, 32'd0);
    end
    m_rx_valid = 1'b1;
    m_rx_data  = v.rx;
    tick();
    m_rx_valid = 1'b0;
    m_rx_data  = 8'h00;
    check_resp(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_cs"}, cs_sel, 32'd0);
    check({tag, "_txv"}, m_tx_valid, 32'd0);
    check({tag, "_txd"}, m_tx_data, 32'd0);
    check({tag, "_respv"}, resp_valid, 32'd0);
    check({tag, "_respd"}, resp_data, 32'd0);
    check({tag, "_err"}, resp_err, 32'd0);
    check({tag, "_ready"}, req_ready, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   n;
    tbl[0]  = '{4'hF, 32'h44332211, 0, 8'h11, 8'hC1, 0,  0};
    tbl[1]  = '{4'hF, 32'h44332211, 1, 8'h22, 8'hC2, 1,  2};
    tbl[2]  = '{4'hF, 32'h44332211, 2, 8'h33, 8'hC3, 0,  1};
    tbl[3]  = '{4'hF, 32'h44332211, 3, 8'h44, 8'hC4, 2,  0};
    tbl[4]  = '{4'hF, 32'h44332211, 0, 8'h11, 8'hC5, 0,  0};
    tbl[5]  = '{4'h4, 32'h00A50000, 2, 8'hA5, 8'h3C, 0,  1};
    tbl[6]  = '{4'h4, 32'h00770000, 2, 8'h77, 8'h5A, 1,  0};
    tbl[7]  = '{4'hA, 32'h9900BB00, 3, 8'h99, 8'h81, 20, 0};
    tbl[8]  = '{4'hA, 32'h9900BB00, 1, 8'hBB, 8'h7E, 0,  2};
    tbl[9]  = '{4'h3, 32'h0000DDEE, 0, 8'hEE, 8'h0F, 0,  0};
    tbl[10] = '{4'h9, 32'h66000055, 3, 8'h66, 8'hF0, 0,  3};

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    m_tx_ready = 1'b0;
    m_rx_data = '0;
    m_rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_txn($sformatf("vec%0d", i), tbl[i]);
    req_valid = '0;

    // Receive strobe with nothing in flight must be ignored.
    m_rx_valid = 1'b1;
    m_rx_data  = 8'hEE;
    tick();
    m_rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("spurious_respv", resp_valid, 32'd0);
      check("spurious_respd", resp_data, 32'hF0);
      check("spurious_busy", busy, 32'd0);
      tick();
    end
    $display("txn spurious: resp_data %0h", resp_data);

    // Reset while waiting for the slave abandons the transaction.
    req_valid = 4'b0010;
    req_data  = 32'h0000BB00;
    #1;
    check("rstwait_ready", req_ready, 32'b0010);
    tick();
    req_valid  = '0;
    m_tx_ready = 1'b1;
    tick();
    m_tx_ready = 1'b0;
    check("rstwait_busy", busy, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rstwait");
    m_rx_valid = 1'b1;
    m_rx_data  = 8'h55;
    @(negedge clk);
    rst = 1'b0;
    m_rx_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rstwait_noresp", resp_valid, 32'd0);
      tick();
    end
    $display("txn reset_in_wait: resp_valid %0h", resp_valid);
    v = '{4'hF, 32'h44332211, 0, 8'h11, 8'h96, 0, 1};
    run_txn("after_rst", v);
    req_valid = '0;

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      exp_t e;
      req_valid = 4'b0100;
      req_data  = 32'h005A0000;
      #1;
      check("to_ready", req_ready, 32'b0100);
      e.grant = 2;
      e.data  = 8'h00;
      e.err   = 1'b1;
      exp_q.push_back(e);
      tick();
      req_valid  = '0;
      m_tx_ready = 1'b1;
      tick();
      m_tx_ready = 1'b0;
      n = 0;
      while (resp_valid == '0 && n < 40) begin
        tick();
        n++;
      end
      check("to_cycles", n, TO);
      check_resp("timeout");
      check("to_err_hold", resp_err, 32'd1);
      v = '{4'h1, 32'h00000042, 0, 8'h42, 8'h24, 0, 2};
      run_txn("after_to", v);
      req_valid = '0;
    end
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
